// File: rtl/regfile_write_queue_if.sv
// Handshake and register-file write bundle for regfile_write_queue.
// master = request source / consumer side, slave = the queue itself.
interface regfile_write_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;
  logic [CntW-1:0]   count;

  modport master (
    output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, q_addr,
    input  mem_ready, alu_ready, wr_en, wr_addr, wr_data, q_hit, q_data, count
  );

  modport slave (
    input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, q_addr,
    output mem_ready, alu_ready, wr_en, wr_addr, wr_data, q_hit, q_data, count
  );
endinterface

// File: rtl/regfile_write_queue.sv
// Write-back queue owning the register file write port: MEM/ALU pushes, one retire per cycle.
// Define WBQ_BYPASS_EN to enable the queued-value lookup port (q_hit/q_data).
module regfile_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input logic                  clk,
  input logic                  rst,
  regfile_write_queue_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q, tail_alu;
  logic [CntW-1:0]   count_q;
  logic              push_mem, push_alu, pop;

  // Readies depend only on registered occupancy, never on this cycle's pop.
  assign bus.mem_ready = count_q < CntW'(DEPTH);
  assign bus.alu_ready = (count_q <= CntW'(DEPTH - 2)) ||
                         (!bus.mem_valid && (count_q < CntW'(DEPTH)));

  assign push_mem = bus.mem_valid && bus.mem_ready;
  assign push_alu = bus.alu_valid && bus.alu_ready;
  assign pop      = count_q != '0;
  assign tail_alu = tail_q + PtrW'(push_mem);

  assign bus.wr_en   = pop;
  assign bus.wr_addr = addr_q[head_q];
  assign bus.wr_data = data_q[head_q];
  assign bus.count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push_mem) begin
        addr_q[tail_q] <= bus.mem_addr;
        data_q[tail_q] <= bus.mem_data;
      end
      if (push_alu) begin
        addr_q[tail_alu] <= bus.alu_addr;
        data_q[tail_alu] <= bus.alu_data;
      end
      head_q  <= head_q + PtrW'(pop);
      tail_q  <= tail_alu + PtrW'(push_alu);
      count_q <= count_q + CntW'(push_mem) + CntW'(push_alu) - CntW'(pop);
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [PtrW-1:0] scan_idx;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    bus.q_hit  = 1'b0;
    bus.q_data = '0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_q[scan_idx] == bus.q_addr)) begin
        bus.q_hit  = 1'b1;
        bus.q_data = data_q[scan_idx];
      end
    end
  end
`else
  assign bus.q_hit  = 1'b0;
  assign bus.q_data = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Randomized and directed bench for regfile_write_queue against a queue-based reference model.
// Compile with the same WBQ_BYPASS_EN setting as the RTL.
module tb_regfile_write_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  entry_t model_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  logic   just_reset;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check #1 later, update model on posedge.
  task automatic cycle(input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                       input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic [ADDR_W-1:0] qa, output logic m_acc, output logic a_acc);
    int   sz;
    logic exp_mr, exp_ar, exp_hit;
    logic [DATA_W-1:0] exp_qd;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.q_addr    = qa;
    #1;
    sz     = model_q.size();
    exp_mr = sz < DEPTH;
    exp_ar = (sz <= DEPTH - 2) || (!mv && sz < DEPTH);
    exp_hit = 1'b0;
    exp_qd  = '0;
`ifdef WBQ_BYPASS_EN
    foreach (model_q[i]) begin
      if (model_q[i].a == qa) begin
        exp_hit = 1'b1;
        exp_qd  = model_q[i].d;
      end
    end
`endif
    check_eq("count", 32'(bus.count), 32'(sz));
    check_eq("wr_en", 32'(bus.wr_en), 32'(sz != 0));
    if (sz != 0) begin
      check_eq("wr_addr", 32'(bus.wr_addr), 32'(model_q[0].a));
      check_eq("wr_data", bus.wr_data, model_q[0].d);
    end else if (just_reset) begin
      check_eq("wr_addr_rst", 32'(bus.wr_addr), 32'd0);
      check_eq("wr_data_rst", bus.wr_data, 32'd0);
    end
    check_eq("mem_ready", 32'(bus.mem_ready), 32'(exp_mr));
    check_eq("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
    check_eq("q_hit", 32'(bus.q_hit), 32'(exp_hit));
    if (exp_hit || just_reset) check_eq("q_data", bus.q_data, exp_qd);
    m_acc = mv && exp_mr;
    a_acc = av && exp_ar;
    @(posedge clk);
    if (model_q.size() != 0) void'(model_q.pop_front());
    if (m_acc) model_q.push_back('{a: ma, d: md});
    if (a_acc) model_q.push_back('{a: aa, d: ad});
    just_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    just_reset = 1'b1;
  endtask

  initial begin
    logic ma_, aa_;
    logic hold_m, hold_a;
    logic mv, av;
    logic [ADDR_W-1:0] ma, aa;
    logic [DATA_W-1:0] md, ad;

    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.q_addr    = '0;
    just_reset    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single write, then drain.
    cycle(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, '0, '0, 3'd3, ma_, aa_);
    repeat (2) cycle(1'b0, '0, '0, 1'b0, '0, '0, 3'd3, ma_, aa_);

    // Dual push, retire in MEM-then-ALU order.
    cycle(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 3'd2, ma_, aa_);
    repeat (3) cycle(1'b0, '0, '0, 1'b0, '0, '0, 3'd1, ma_, aa_);

    // Same-address ordering and lookup of the youngest value.
    cycle(1'b1, 3'd5, 32'hA, 1'b0, '0, '0, 3'd5, ma_, aa_);
    cycle(1'b1, 3'd5, 32'hB, 1'b0, '0, '0, 3'd5, ma_, aa_);
    repeat (3) cycle(1'b0, '0, '0, 1'b0, '0, '0, 3'd5, ma_, aa_);
    cycle(1'b1, 3'd5, 32'hA, 1'b1, 3'd5, 32'hB, 3'd5, ma_, aa_);
    repeat (3) cycle(1'b0, '0, '0, 1'b0, '0, '0, 3'd5, ma_, aa_);

    // Wrap: ten sequential pushes to r7.
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'd7, 32'(i), 1'b0, '0, '0, 3'd7, ma_, aa_);
    repeat (2) cycle(1'b0, '0, '0, 1'b0, '0, '0, 3'd7, ma_, aa_);

    // Fill / backpressure with held requests, sequential data as scoreboard tags.
    md = 32'h100; ad = 32'h200;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 3'(i), md, 1'b1, 3'(i + 4), ad, 3'(i), ma_, aa_);
      if (ma_) md++;
      if (aa_) ad++;
    end

    // Reset mid-operation (queue is at DEPTH-1 here).
    do_reset();
    repeat (3) cycle(1'b0, '0, '0, 1'b0, '0, '0, 3'd0, ma_, aa_);

    // Random traffic; sources hold an unaccepted request stable.
    hold_m = 1'b0; hold_a = 1'b0;
    mv = 1'b0; av = 1'b0; ma = '0; aa = '0; md = '0; ad = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold_m) begin
        mv = $urandom_range(0, 99) < 55;
        ma = 3'($urandom_range(0, 7));
        md = $urandom;
      end
      if (!hold_a) begin
        av = $urandom_range(0, 99) < 55;
        aa = 3'($urandom_range(0, 7));
        ad = $urandom;
      end
      cycle(mv, ma, md, av, aa, ad, 3'($urandom_range(0, 7)), ma_, aa_);
      hold_m = mv && !ma_;
      hold_a = av && !aa_;
    end
    repeat (DEPTH + 1) cycle(1'b0, '0, '0, 1'b0, '0, '0, 3'd0, ma_, aa_);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
